div_64: RTL and testbench

- Sequential unsigned 128/64 divider; the inverse of the 64x64 multiplier datapath.
- Takes a 128-bit dividend and a 64-bit divisor. Returns a 64-bit quotient, a 64-bit remainder and status flags.
- Radix-2 restoring algorithm, one quotient bit per cycle.
- Sits beside the multiplier in the arithmetic unit, behind a valid/ready handshake on both sides.

---
 rtl/arith_pkg.sv | 17 +
 rtl/div_64_if.sv | 27 ++
 rtl/div_step.sv | 22 ++
 rtl/div_64.sv | 124 ++++++++++++
 tb/tb_div_64.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit constants and types for the sequential divider.
// Also used by the DIV64_FAST_EXCEPTION_EN build of div_64.
package arith_pkg;

    localparam int W     = 64;
    localparam int CNT_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Quotient returned for divide-by-zero and quotient overflow.
    localparam logic [W-1:0] EXC_QUOTIENT = {W{1'b1}};

endpackage

// File: rtl/div_64_if.sv
// Operand/result handshake bundle between an arithmetic-unit client and div_64.
// master = operand source / result consumer, slave = divider.
interface div_64_if;
    import arith_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_zero;
    logic           ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero, ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero, ovf
    );

endinterface

// File: rtl/div_step.sv
// One combinational radix-2 restoring iteration: shift in one dividend bit,
// trial-subtract the divisor on the full W+1 bit partial remainder.
module div_step
    import arith_pkg::*;
(
    input  logic [W-1:0] r,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] r_next,
    output logic         q_bit
);

    logic [W:0] t;

    always_comb begin
        t      = {r, bit_in};
        q_bit  = (t >= {1'b0, divisor});
        // When the subtract succeeds the result is < divisor, so the low W bits are exact.
        r_next = q_bit ? (t[W-1:0] - divisor) : t[W-1:0];
    end

endmodule

// File: rtl/div_64.sv
// Sequential unsigned 128/64 restoring divider, one quotient bit per cycle.
// Optional macro DIV64_FAST_EXCEPTION_EN: divide-by-zero/overflow finish after one cycle.
//
// state | meaning
// IDLE  | ready for operands
// BUSY  | iterating, one quotient bit per edge
// DONE  | result held until out_ready
module div_64
    import arith_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    div_64_if.slave  bus
);

    div_state_e       state;
    div_state_e       state_next;
    logic [W-1:0]     r_q;
    logic [W-1:0]     q_q;
    logic [W-1:0]     dvs_q;
    logic [W-1:0]     lo_q;
    logic [CNT_W-1:0] cnt;
    logic             dz_q;
    logic             of_q;
    logic [W-1:0]     quo_q;
    logic [W-1:0]     rem_q;
    logic             div_zero_q;
    logic             ovf_q;
    logic [W-1:0]     r_next;
    logic             q_bit;
    logic             accept;
    logic             last_iter;
    logic             exc_done;

    div_step u_step (
        .r       (r_q),
        .bit_in  (q_q[W-1]),
        .divisor (dvs_q),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

    assign accept    = bus.in_valid && (state == IDLE);
    assign last_iter = (cnt == CNT_W'(W - 1));

`ifdef DIV64_FAST_EXCEPTION_EN
    // Exceptions leave BUSY on its first edge, so out_valid rises one edge after acceptance.
    assign exc_done = dz_q | of_q;
`else
    assign exc_done = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (last_iter || exc_done) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q        <= '0;
            q_q        <= '0;
            dvs_q      <= '0;
            lo_q       <= '0;
            cnt        <= '0;
            dz_q       <= 1'b0;
            of_q       <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvs_q <= bus.divisor;
                        r_q   <= bus.dividend[2*W-1:W];
                        q_q   <= bus.dividend[W-1:0];
                        lo_q  <= bus.dividend[W-1:0];
                        dz_q  <= (bus.divisor == '0);
                        of_q  <= (bus.divisor != '0) && (bus.dividend[2*W-1:W] >= bus.divisor);
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    r_q <= r_next;
                    q_q <= {q_q[W-2:0], q_bit};
                    cnt <= cnt + CNT_W'(1);
                    if (state_next == DONE) begin
                        if (dz_q || of_q) begin
                            quo_q      <= EXC_QUOTIENT;
                            rem_q      <= lo_q;
                            div_zero_q <= dz_q;
                            ovf_q      <= of_q;
                        end else begin
                            quo_q      <= {q_q[W-2:0], q_bit};
                            rem_q      <= r_next;
                            div_zero_q <= 1'b0;
                            ovf_q      <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_div_64.sv
// Self-checking bench for div_64: arithmetic reference model + scoreboard,
// directed vectors with literal expectations, and random in-range operands.
module tb_div_64;
    import arith_pkg::*;

`ifdef DIV64_FAST_EXCEPTION_EN
    localparam int EXC_LAT = 1;
`else
    localparam int EXC_LAT = 64;
`endif

    typedef struct packed {
        logic [2*W-1:0] dvd;
        logic [W-1:0]   dvs;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           dz;
        logic           of;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_64_if bus();
    div_64 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t sb[$];
    exp_t cur;
    exp_t pin;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        exp_t e;
        logic [2*W-1:0] qq;
        logic [2*W-1:0] rr;
        e.dvd = dvd;
        e.dvs = dvs;
        e.dz  = 1'b0;
        e.of  = 1'b0;
        e.q   = '1;
        e.r   = dvd[W-1:0];
        if (dvs == '0) begin
            e.dz = 1'b1;
        end else if (dvd[2*W-1:W] >= dvs) begin
            e.of = 1'b1;
        end else begin
            qq  = dvd / {{W{1'b0}}, dvs};
            rr  = dvd % {{W{1'b0}}, dvs};
            e.q = qq[W-1:0];
            e.r = rr[W-1:0];
        end
        return e;
    endfunction

    // Scoreboard compare on every cycle the result is presented (covers hold-stability too).
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 128'(bus.out_valid), 128'(0));
            end else begin
                cur = sb[0];
                check("quotient",  128'(bus.quotient),  128'(cur.q));
                check("remainder", 128'(bus.remainder), 128'(cur.r));
                check("div_zero",  128'(bus.div_zero),  128'(cur.dz));
                check("ovf",       128'(bus.ovf),       128'(cur.of));
                check("in_ready_in_done", 128'(bus.in_ready), 128'(0));
                if (!cur.dz && !cur.of) begin
                    check("invariant", 128'(bus.quotient) * 128'(cur.dvs) + 128'(bus.remainder), cur.dvd);
                    check("rem_lt_div", 128'(bus.remainder < cur.dvs), 128'(1));
                end
                if (bus.out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic send(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        int n = 0;
        while (!bus.in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 128'(bus.in_ready), 128'(1));
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.in_valid = 1'b1;
        sb.push_back(model(dvd, dvs));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input int exp_lat);
        int lat = 0;
        while (!bus.out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 128'(lat), 128'(exp_lat));
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("in_ready_after_pop", 128'(bus.in_ready), 128'(1));
        check("out_valid_after_pop", 128'(bus.out_valid), 128'(0));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  128'(bus.in_ready),  128'(1));
        check({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
        check({tag, "_quotient"},  128'(bus.quotient),  128'(0));
        check({tag, "_remainder"}, 128'(bus.remainder), 128'(0));
        check({tag, "_div_zero"},  128'(bus.div_zero),  128'(0));
        check({tag, "_ovf"},       128'(bus.ovf),       128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] hi;
        logic [W-1:0] lo;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");
        rst_n = 1'b1;

        // Model pinned against hand-computed values.
        pin = model(128'd100, 64'd7);
        check("model_q_100_7", 128'(pin.q), 128'd14);
        check("model_r_100_7", 128'(pin.r), 128'd2);
        pin = model(128'h5_0000_0000_0000_0009, 64'd5);
        check("model_of", 128'(pin.of), 128'd1);

        send(128'd100, 64'd7);
        wait_result(64);
        check("lit_q_100_7", 128'(bus.quotient), 128'd14);
        check("lit_r_100_7", 128'(bus.remainder), 128'd2);
        check("lit_flags_100_7", 128'({bus.div_zero, bus.ovf}), 128'd0);
        release_result();

        send({64'h1, 64'h0}, 64'h2);
        wait_result(64);
        check("lit_q_pow2", 128'(bus.quotient), 128'h8000_0000_0000_0000);
        check("lit_r_pow2", 128'(bus.remainder), 128'd0);
        release_result();

        send({64'h1234, 64'hDEAD_BEEF}, 64'h0);
        wait_result(EXC_LAT);
        check("lit_dz_flag", 128'(bus.div_zero), 128'd1);
        check("lit_dz_q", 128'(bus.quotient), 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
        check("lit_dz_r", 128'(bus.remainder), 128'hDEAD_BEEF);
        release_result();

        send({64'h5, 64'h77}, 64'h5);
        wait_result(EXC_LAT);
        check("lit_ovf_flag", 128'(bus.ovf), 128'd1);
        check("lit_ovf_dz", 128'(bus.div_zero), 128'd0);
        check("lit_ovf_q", 128'(bus.quotient), 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
        check("lit_ovf_r", 128'(bus.remainder), 128'h77);
        release_result();

        // Boundary: hi = divisor-1 keeps a W+1 bit partial remainder live every step.
        send({64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF}, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_result(64);
        check("lit_q_max", 128'(bus.quotient), 128'hFFFF_FFFF_FFFF_FFFF);
        check("lit_r_max", 128'(bus.remainder), 128'hFFFF_FFFF_FFFF_FFFE);
        release_result();

        // Backpressure with ignored operand pulses.
        send(128'd1000, 64'd9);
        wait_result(64);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = i[0];
            bus.dividend = 128'(i + 3);
            bus.divisor  = 64'd1;
            @(posedge clk); #1;
            check("bp_in_ready", 128'(bus.in_ready), 128'd0);
            check("bp_out_valid", 128'(bus.out_valid), 128'd1);
        end
        bus.in_valid = 1'b0;
        check("lit_q_bp", 128'(bus.quotient), 128'd111);
        check("lit_r_bp", 128'(bus.remainder), 128'd1);
        release_result();

        for (int i = 0; i < 3; i++) begin
            send(128'(64'd50000 + 64'(i)), 64'(i + 3));
            wait_result(64);
            release_result();
        end

        // Reset mid-division discards the operation and clears the outputs.
        send(128'd100, 64'd7);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        check_reset_state("rst");
        @(posedge clk); #1;
        check_reset_state("rst_after");

        send(128'd100, 64'd7);
        wait_result(64);
        release_result();

        for (int i = 0; i < 200; i++) begin
            d = {$urandom, $urandom};
            if (d == '0) d = 64'd1;
            hi = {$urandom, $urandom};
            hi = hi % d;
            lo = {$urandom, $urandom};
            send({hi, lo}, d);
            wait_result(64);
            release_result();
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 128'(sb.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
